// File: rtl/keypoint_reader_if.sv
// Keypoint stream from the SRAM reader to the orientation/descriptor stage.
// The head entry is offered with valid and is consumed on a cycle with valid && ready.
interface keypoint_reader_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10
);
  logic             kp_valid;
  logic             kp_ready;
  logic [ROW_W-1:0] kp_row;
  logic [COL_W-1:0] kp_col;
  logic             kp_layer;
  logic             kp_last;

  modport master (output kp_valid, kp_row, kp_col, kp_layer, kp_last, input kp_ready);
  modport slave  (input kp_valid, kp_row, kp_col, kp_layer, kp_last, output kp_ready);
endinterface

// File: rtl/keypoint_reader.sv
// Streams every keypoint stored in the two per-layer SRAMs (layer 1 first, then layer 2)
// through a 2-entry FIFO that hides the 1-cycle SRAM read latency.
module keypoint_reader #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 9,
  parameter int COL_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W:0]        kp1_count,
  input  logic [ADDR_W:0]        kp2_count,
  output logic [ADDR_W-1:0]      keypoint_1_addr,
  input  logic [ROW_W+COL_W-1:0] keypoint_1_dout,
  output logic [ADDR_W-1:0]      keypoint_2_addr,
  input  logic [ROW_W+COL_W-1:0] keypoint_2_dout,
  keypoint_reader_if.master      kp,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = ROW_W + COL_W;
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RD1, RD2, DRAIN, FIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   cnt1_q, cnt2_q;
  logic [ADDR_W-1:0] addr1, addr2;
  logic              inflight, infl_layer, infl_last;
  logic [DW+1:0]     fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              busy_q;

  logic              pop, push, credit;
  logic              issue1, issue2, issue_last;
  logic              last1, last2;
  logic [1:0]        occ;
  logic [DW-1:0]     dout_sel;
  logic [DW+1:0]     head;

  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  // A pop in the same cycle frees a slot, which keeps one issue per cycle at full rate.
  assign pop      = kp.kp_valid && kp.kp_ready;
  assign push     = inflight;
  assign occ      = fifo_cnt + {1'b0, inflight};
  assign credit   = (occ < 2'd2) || pop;
  assign last1    = ({1'b0, addr1} == (cnt1_q - ONE));
  assign last2    = ({1'b0, addr2} == (cnt2_q - ONE));
  assign dout_sel = infl_layer ? keypoint_2_dout : keypoint_1_dout;

  assign head        = fifo_mem[rd_ptr];
  assign kp.kp_valid = (fifo_cnt != 2'd0);
  assign kp.kp_row   = head[DW-1:COL_W];
  assign kp.kp_col   = head[COL_W-1:0];
  assign kp.kp_layer = head[DW];
  assign kp.kp_last  = head[DW+1] && kp.kp_valid;

  assign keypoint_1_addr = addr1;
  assign keypoint_2_addr = addr2;
  assign busy            = busy_q;

  always_comb begin
    state_next = state;
    issue1     = 1'b0;
    issue2     = 1'b0;
    issue_last = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (kp1_count != '0)      state_next = RD1;
          else if (kp2_count != '0) state_next = RD2;
          else                      state_next = FIN;
        end
      end
      RD1: begin
        if (credit) begin
          issue1 = 1'b1;
          if (last1) begin
            issue_last = (cnt2_q == '0);
            state_next = (cnt2_q != '0) ? RD2 : DRAIN;
          end
        end
      end
      RD2: begin
        if (credit) begin
          issue2 = 1'b1;
          if (last2) begin
            issue_last = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      // Leave as soon as the final entry is being popped so done lands right after it.
      DRAIN: begin
        if (!inflight && ((fifo_cnt == 2'd0) || (fifo_cnt == 2'd1 && pop)))
          state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      addr1      <= '0;
      addr2      <= '0;
      inflight   <= 1'b0;
      infl_layer <= 1'b0;
      infl_last  <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_next;
      inflight   <= issue1 || issue2;
      infl_layer <= issue2;
      infl_last  <= issue_last;
      if (state == IDLE && start) begin
        cnt1_q <= sat_count(kp1_count);
        cnt2_q <= sat_count(kp2_count);
        busy_q <= 1'b1;
      end
      if (state == FIN) begin
        busy_q <= 1'b0;
        addr1  <= '0;
        addr2  <= '0;
      end
      if (issue1) addr1 <= addr1 + 1'b1;
      if (issue2) addr2 <= addr2 + 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {infl_last, infl_layer, dout_sel};
  end

endmodule

// File: tb/tb_keypoint_reader.sv
// Bench for keypoint_reader: SRAM models, a scoreboard queue of expected keypoints,
// a table of read-out scenarios and hand-written reset/start corner sequences.
module tb_keypoint_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] kp1_count = '0;
  logic [11:0] kp2_count = '0;
  logic [10:0] keypoint_1_addr, keypoint_2_addr;
  logic [18:0] keypoint_1_dout, keypoint_2_dout;
  logic        busy, done;

  logic [18:0] sram1 [2048];
  logic [18:0] sram2 [2048];

  keypoint_reader_if #(.ROW_W(9), .COL_W(10)) kp_bus ();

  keypoint_reader #(.ADDR_W(11), .ROW_W(9), .COL_W(10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .kp1_count       (kp1_count),
    .kp2_count       (kp2_count),
    .keypoint_1_addr (keypoint_1_addr),
    .keypoint_1_dout (keypoint_1_dout),
    .keypoint_2_addr (keypoint_2_addr),
    .keypoint_2_dout (keypoint_2_dout),
    .kp              (kp_bus),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    keypoint_1_dout <= sram1[keypoint_1_addr];
    keypoint_2_dout <= sram2[keypoint_2_addr];
  end

  typedef struct {
    int k1;
    int k2;
    int mode;
    int restart;
    int exp_xfer;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  logic [20:0] exp_q[$];
  int          xfer_count, done_count, first_xfer_cycle, last_xfer_cycle;
  int          max_addr1;
  logic        addr1_moved, addr2_moved;
  logic [20:0] first_bundle, prev_bundle;
  logic        prev_stall = 1'b0;
  logic [20:0] bundle;

  assign bundle = {kp_bus.kp_row, kp_bus.kp_col, kp_bus.kp_layer, kp_bus.kp_last};

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor samples on the falling edge, midway between active edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_output("hold_while_stalled", {kp_bus.kp_valid, bundle}, {1'b1, prev_bundle});
      if (kp_bus.kp_valid && kp_bus.kp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_xfer: got %0h expected none", bundle);
        end else begin
          check_output("kp_data", bundle, exp_q.pop_front());
        end
        if (xfer_count == 0) begin
          first_xfer_cycle = cycle;
          first_bundle     = bundle;
        end
        last_xfer_cycle = cycle;
        xfer_count++;
      end
      if (done) begin
        done_count++;
        if (xfer_count > 0) check_output("done_after_last", cycle, last_xfer_cycle + 1);
      end
      if (int'(keypoint_1_addr) > max_addr1) max_addr1 = int'(keypoint_1_addr);
      if (keypoint_1_addr != 0) addr1_moved = 1'b1;
      if (keypoint_2_addr != 0) addr2_moved = 1'b1;
      prev_stall  = kp_bus.kp_valid && !kp_bus.kp_ready;
      prev_bundle = bundle;
    end
  end

  task automatic push_expected(input int k1, input int k2);
    int s1 = (k1 > 2048) ? 2048 : k1;
    int s2 = (k2 > 2048) ? 2048 : k2;
    for (int i = 0; i < s1; i++) begin
      logic [18:0] d = sram1[i];
      exp_q.push_back({d[18:10], d[9:0], 1'b0, (i == s1 - 1) && (s2 == 0)});
    end
    for (int i = 0; i < s2; i++) begin
      logic [18:0] d = sram2[i];
      exp_q.push_back({d[18:10], d[9:0], 1'b1, i == s2 - 1});
    end
  endtask

  task automatic clear_run();
    xfer_count  = 0;
    done_count  = 0;
    max_addr1   = 0;
    addr1_moved = 1'b0;
    addr2_moved = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic apply_stimulus(input vec_t v);
    int budget;
    push_expected(v.k1, v.k2);
    clear_run();
    budget = 4 * (((v.k1 > 2048) ? 2048 : v.k1) + v.k2) + 20;
    @(posedge clk); #1;
    kp_bus.kp_ready = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    kp1_count = 12'(v.k1);
    kp2_count = 12'(v.k2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", busy, 1);
    for (int c = 0; c < budget && done_count == 0; c++) begin
      case (v.mode)
        1:       kp_bus.kp_ready = (c % 3 == 0);
        2:       kp_bus.kp_ready = 1'($urandom_range(0, 1));
        default: kp_bus.kp_ready = 1'b1;
      endcase
      if (v.restart != 0 && c == 1) begin
        start = 1'b1;
        kp1_count = 12'd7;
        kp2_count = 12'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    kp_bus.kp_ready = 1'b1;
    if (done_count == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
    #1;
    check_output("xfer_count", xfer_count, v.exp_xfer);
    check_output("done_once", done_count, 1);
    check_output("queue_empty", exp_q.size(), 0);
    check_output("busy_cleared", busy, 0);
    if (v.mode == 0 && v.exp_xfer > 0)
      check_output("back_to_back", last_xfer_cycle - first_xfer_cycle, v.exp_xfer - 1);
    if (v.k1 == 0) check_output("addr1_stays_zero", addr1_moved, 0);
    if (v.k2 == 0) check_output("addr2_stays_zero", addr2_moved, 0);
    if (v.k1 >= 2048) check_output("addr1_max", max_addr1, 2047);
    exp_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    kp_bus.kp_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      sram1[i] = 19'($urandom);
      sram2[i] = 19'($urandom);
    end
    sram1[0] = 19'h5_0A3F;

    vecs[0] = '{3, 2, 0, 0, 5};
    vecs[1] = '{0, 0, 0, 0, 0};
    vecs[2] = '{4, 0, 1, 0, 4};
    vecs[3] = '{1, 3, 2, 1, 4};
    vecs[4] = '{0, 2, 0, 0, 2};
    vecs[5] = '{2048, 1, 0, 0, 2049};
    vecs[6] = '{4095, 0, 0, 0, 2048};
    vecs[7] = '{5, 5, 2, 0, 10};

    clear_run();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", kp_bus.kp_valid, 0);
    check_output("reset_last", kp_bus.kp_last, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_addrs", {keypoint_1_addr, keypoint_2_addr}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      if (i == 0)
        check_output("first_entry_fields", first_bundle[20:1], {9'h142, 10'h23F, 1'b0});
    end

    // start held into the FIN cycle must not launch a second read-out
    clear_run();
    @(posedge clk); #1;
    kp1_count = 12'd0;
    kp2_count = 12'd0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("start_in_fin_ignored", done_count, 1);

    // reset in the middle of layer 1, then a clean single-entry read-out
    push_expected(5, 0);
    clear_run();
    @(posedge clk); #1;
    kp1_count = 12'd5;
    kp2_count = 12'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && xfer_count < 2; c++) @(negedge clk);
    check_output("two_xfers_before_reset", xfer_count >= 2, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    done_count = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("abort_valid", kp_bus.kp_valid, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_addr1", keypoint_1_addr, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("abort_no_done", done_count, 0);
    apply_stimulus('{1, 0, 0, 0, 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
